// File: rtl/weight_div_pkg.sv
// ----------------------------------------------------------------------------
// weight_div_pkg
// Shared constants and types for the weight de-normalisation divider.
//   DATA_W   : dividend / quotient width (signed)
//   WEIGHT_W : weight width (signed milli-units, scale 1000)
//   SCALE    : weight scale factor (1000), SCALE_W bits wide
//   NUM_W    : width of the scaled numerator |dividend| * SCALE
//   CNT_W    : width of the divider iteration counter
//   state_t  : controller states
// ----------------------------------------------------------------------------
package weight_div_pkg;

    localparam int DATA_W   = 32;
    localparam int WEIGHT_W = 10;
    localparam int SCALE    = 1000;
    localparam int SCALE_W  = 10;
    localparam int NUM_W    = DATA_W + SCALE_W;
    localparam int CNT_W    = $clog2(NUM_W);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        LOAD = 2'd1,
        DIV  = 2'd2,
        DONE = 2'd3
    } state_t;

endpackage

// File: rtl/weight_divide_if.sv
// ----------------------------------------------------------------------------
// weight_divide_if
// Start/done request interface of the weight divider.
//   start    : request, sampled only while the divider is idle
//   dividend : signed numerator, sampled with start
//   weight   : signed divisor in milli-units, sampled with start
//   busy     : operation in flight (LOAD through DONE)
//   done     : one-cycle result strobe
//   quotient : signed saturated result, held until the next done
//   ovf      : result saturated
//   div_zero : weight was zero
// master drives the request, slave is the divider.
// ----------------------------------------------------------------------------
interface weight_divide_if;
    import weight_div_pkg::*;

    logic                       start;
    logic signed [DATA_W-1:0]   dividend;
    logic signed [WEIGHT_W-1:0] weight;
    logic                       busy;
    logic                       done;
    logic signed [DATA_W-1:0]   quotient;
    logic                       ovf;
    logic                       div_zero;

    modport master (
        output start, dividend, weight,
        input  busy, done, quotient, ovf, div_zero
    );

    modport slave (
        input  start, dividend, weight,
        output busy, done, quotient, ovf, div_zero
    );

endinterface

// File: rtl/weight_divide_udiv_seq.sv
// ----------------------------------------------------------------------------
// udiv_seq
// Unsigned NUM_W / WEIGHT_W restoring divider, one quotient bit per step.
//   clk, rst : clock, synchronous active-high reset
//   load     : capture num/den, clear remainder, counter = NUM_W-1
//   step     : perform one restoring iteration (MSB first)
//   num, den : unsigned numerator / non-zero divisor
//   quo_next : quotient as it will stand after the current step
//   last     : the current step is the final one
// ----------------------------------------------------------------------------
module udiv_seq
    import weight_div_pkg::*;
(
    input  logic                clk,
    input  logic                rst,
    input  logic                load,
    input  logic                step,
    input  logic [NUM_W-1:0]    num,
    input  logic [WEIGHT_W-1:0] den,
    output logic [NUM_W-1:0]    quo_next,
    output logic                last
);

    // The numerator register doubles as the quotient register: numerator
    // bits leave at the MSB while quotient bits enter at the LSB.
    logic [NUM_W-1:0]    acc_q;
    logic [WEIGHT_W-1:0] den_q;
    logic [WEIGHT_W-1:0] rem_q;
    logic [CNT_W-1:0]    cnt_q;

    logic [WEIGHT_W:0]   rem_sh;
    logic [WEIGHT_W:0]   rem_diff;
    logic                fits;

    // rem_q < den_q <= 2^(WEIGHT_W-1), so rem_sh never reaches 2^WEIGHT_W and
    // the top bit of the difference is a clean borrow.
    always_comb begin
        rem_sh   = {rem_q, acc_q[NUM_W-1]};
        rem_diff = rem_sh - {1'b0, den_q};
        fits     = ~rem_diff[WEIGHT_W];
        quo_next = {acc_q[NUM_W-2:0], fits};
    end

    assign last = (cnt_q == '0);

    always_ff @(posedge clk) begin
        if (rst) begin
            acc_q <= '0;
            den_q <= '0;
            rem_q <= '0;
            cnt_q <= '0;
        end else if (load) begin
            acc_q <= num;
            den_q <= den;
            rem_q <= '0;
            cnt_q <= CNT_W'(NUM_W - 1);
        end else if (step) begin
            acc_q <= quo_next;
            rem_q <= fits ? rem_diff[WEIGHT_W-1:0] : rem_sh[WEIGHT_W-1:0];
            if (!last) begin
                cnt_q <= cnt_q - 1'b1;
            end
        end
    end

endmodule

// File: rtl/weight_divide.sv
// ----------------------------------------------------------------------------
// weight_divide
// Signed divider computing trunc(dividend * 1000 / weight) with saturation,
// used to undo hidden-layer weight scaling.
//   clk, rst : clock, synchronous active-high reset
//   io       : weight_divide_if slave (start/dividend/weight in,
//              busy/done/quotient/ovf/div_zero out)
//
// state | meaning
// ------+---------------------------------------------------------------
// IDLE  | waiting for start; operands captured on acceptance
// LOAD  | magnitudes, sign and x1000 numerator formed; zero weight trapped
// DIV   | one restoring step per cycle, NUM_W steps
// DONE  | done strobe; signed, saturated result presented
// ----------------------------------------------------------------------------
module weight_divide
    import weight_div_pkg::*;
(
    input  logic            clk,
    input  logic            rst,
    weight_divide_if.slave  io
);

    localparam logic [DATA_W-1:0] Q_MAX = {1'b0, {(DATA_W-1){1'b1}}};
    localparam logic [DATA_W-1:0] Q_MIN = {1'b1, {(DATA_W-1){1'b0}}};

    state_t                     state_q;
    state_t                     state_next;

    logic signed [DATA_W-1:0]   dividend_q;
    logic signed [WEIGHT_W-1:0] weight_q;
    logic                       sign_q;
    logic [DATA_W-1:0]          quotient_q;
    logic                       ovf_q;
    logic                       div_zero_q;

    logic [DATA_W-1:0]          mag_d;
    logic [WEIGHT_W-1:0]        mag_w;
    logic [NUM_W-1:0]           num_scaled;

    logic                       div_load;
    logic                       div_step;
    logic [NUM_W-1:0]           quo_next;
    logic                       div_last;

    logic [DATA_W-1:0]          sat_q;
    logic                       sat_ovf;

    // Unsigned magnitudes: the most negative values map onto 2^(W-1).
    always_comb begin
        mag_d      = dividend_q[DATA_W-1] ? DATA_W'(-dividend_q) : DATA_W'(dividend_q);
        mag_w      = weight_q[WEIGHT_W-1] ? WEIGHT_W'(-weight_q) : WEIGHT_W'(weight_q);
        num_scaled = NUM_W'(mag_d) * NUM_W'(SCALE);
    end

    udiv_seq u_div (
        .clk      (clk),
        .rst      (rst),
        .load     (div_load),
        .step     (div_step),
        .num      (num_scaled),
        .den      (mag_w),
        .quo_next (quo_next),
        .last     (div_last)
    );

    // Sign and saturation act on the final-step quotient so the result lands
    // on the same edge that enters DONE.
    always_comb begin
        sat_q   = '0;
        sat_ovf = 1'b0;
        if (!sign_q) begin
            sat_ovf = (quo_next > NUM_W'(Q_MAX));
            sat_q   = sat_ovf ? Q_MAX : quo_next[DATA_W-1:0];
        end else begin
            sat_ovf = (quo_next > NUM_W'(Q_MIN));
            sat_q   = sat_ovf ? Q_MIN : DATA_W'(-quo_next[DATA_W-1:0]);
        end
    end

    always_comb begin
        state_next = state_q;
        div_load   = 1'b0;
        div_step   = 1'b0;
        case (state_q)
            IDLE: begin
                if (io.start) begin
                    state_next = LOAD;
                end
            end
            LOAD: begin
                if (weight_q == '0) begin
                    state_next = DONE;
                end else begin
                    div_load   = 1'b1;
                    state_next = DIV;
                end
            end
            DIV: begin
                div_step = 1'b1;
                if (div_last) begin
                    state_next = DONE;
                end
            end
            DONE: begin
                state_next = IDLE;
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= IDLE;
            dividend_q <= '0;
            weight_q   <= '0;
            sign_q     <= 1'b0;
            quotient_q <= '0;
            ovf_q      <= 1'b0;
            div_zero_q <= 1'b0;
        end else begin
            state_q <= state_next;
            if (state_q == IDLE && io.start) begin
                dividend_q <= io.dividend;
                weight_q   <= io.weight;
                ovf_q      <= 1'b0;
                div_zero_q <= 1'b0;
            end
            if (state_q == LOAD) begin
                sign_q <= dividend_q[DATA_W-1] ^ weight_q[WEIGHT_W-1];
                if (weight_q == '0) begin
                    quotient_q <= dividend_q[DATA_W-1] ? Q_MIN : Q_MAX;
                    ovf_q      <= 1'b0;
                    div_zero_q <= 1'b1;
                end
            end
            if (state_q == DIV && div_last) begin
                quotient_q <= sat_q;
                ovf_q      <= sat_ovf;
            end
        end
    end

    assign io.busy     = (state_q != IDLE);
    assign io.done     = (state_q == DONE);
    assign io.quotient = quotient_q;
    assign io.ovf      = ovf_q;
    assign io.div_zero = div_zero_q;

endmodule

// File: tb/tb_weight_divide.sv
// ----------------------------------------------------------------------------
// tb_weight_divide
// Directed-vector bench for weight_divide with hand-computed expectations.
// ----------------------------------------------------------------------------
module tb_weight_divide;

    logic clk;
    logic rst;
    int   n_cmp;
    int   n_bad;
    logic prev_done;

    weight_divide_if io ();

    weight_divide dut (
        .clk (clk),
        .rst (rst),
        .io  (io.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic check_idle(input string tag);
        logic [31:0] q_obs;
        q_obs = io.quotient;
        check({tag, ".busy"},     64'(io.busy),     64'd0);
        check({tag, ".done"},     64'(io.done),     64'd0);
        check({tag, ".quotient"}, 64'(q_obs),       64'd0);
        check({tag, ".ovf"},      64'(io.ovf),      64'd0);
        check({tag, ".div_zero"}, 64'(io.div_zero), 64'd0);
    endtask

    // One operation; start is high in cycle 0, n counts cycles after it.
    // A non-zero glitch asserts a spurious start (with other operands) in
    // that cycle.
    task automatic run_op(input string tag, input logic signed [31:0] d,
                          input logic signed [9:0] w, input logic [31:0] eq,
                          input logic eo, input logic ez, input int elat,
                          input int glitch);
        int          n;
        logic        seen;
        logic        busy_ok;
        logic [31:0] q_obs;
        @(negedge clk);
        io.start    = 1'b1;
        io.dividend = d;
        io.weight   = w;
        @(negedge clk);
        io.start = 1'b0;
        n        = 1;
        seen     = 1'b0;
        busy_ok  = 1'b1;
        while (!seen && n < 100) begin
            if (io.busy !== 1'b1) busy_ok = 1'b0;
            if (io.done === 1'b1) begin
                seen = 1'b1;
            end else begin
                @(negedge clk);
                n++;
                if (n == glitch) begin
                    io.start    = 1'b1;
                    io.dividend = 32'sd1;
                    io.weight   = 10'sd1;
                end else begin
                    io.start = 1'b0;
                end
            end
        end
        q_obs = io.quotient;
        check({tag, ".latency"},  64'(n),           64'(elat));
        check({tag, ".quotient"}, 64'(q_obs),       64'(eq));
        check({tag, ".ovf"},      64'(io.ovf),      64'(eo));
        check({tag, ".div_zero"}, 64'(io.div_zero), 64'(ez));
        check({tag, ".busy_run"}, 64'(busy_ok),     64'd1);
        @(negedge clk);
        check({tag, ".busy_after"}, 64'(io.busy), 64'd0);
        check({tag, ".done_after"}, 64'(io.done), 64'd0);
    endtask

    task automatic run_reset_mid();
        int ndone;
        ndone = 0;
        @(negedge clk);
        io.start    = 1'b1;
        io.dividend = 32'sd500;
        io.weight   = 10'sd250;
        @(negedge clk);
        io.start = 1'b0;
        repeat (19) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check_idle("rst_mid");
        repeat (60) begin
            @(negedge clk);
            if (io.done === 1'b1) ndone++;
        end
        check("rst_no_done", 64'(ndone), 64'd0);
    endtask

    always @(negedge clk) begin
        if (prev_done === 1'b1) check("done_single", 64'(io.done), 64'd0);
        prev_done = io.done;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        n_cmp       = 0;
        n_bad       = 0;
        prev_done   = 1'b0;
        rst         = 1'b1;
        io.start    = 1'b0;
        io.dividend = '0;
        io.weight   = '0;
        repeat (3) @(negedge clk);
        check_idle("reset");
        rst = 1'b0;

        run_op("pos",      32'sd500,        10'sd250,  32'd2000,        1'b0, 1'b0, 44, 0);
        run_op("trunc",    -32'sd7,         10'sd3,    -32'sd2333,      1'b0, 1'b0, 44, 0);
        run_op("wmin",     32'sd100,        10'h200,   -32'sd195,       1'b0, 1'b0, 44, 0);
        run_op("dz_neg",   -32'sd5,         10'sd0,    32'h8000_0000,   1'b0, 1'b1, 2,  0);
        run_op("dz_pos",   32'sd5,          10'sd0,    32'h7FFF_FFFF,   1'b0, 1'b1, 2,  0);
        run_op("ovf_pos",  32'h7FFF_FFFF,   10'sd1,    32'h7FFF_FFFF,   1'b1, 1'b0, 44, 0);
        run_op("ovf_neg",  32'h8000_0000,   10'sd1,    32'h8000_0000,   1'b1, 1'b0, 44, 0);
        run_op("edge_pos", 32'sd2147483,    10'sd1,    32'd2147483000,  1'b0, 1'b0, 44, 0);
        run_op("edge_ovf", 32'sd2147484,    10'sd1,    32'h7FFF_FFFF,   1'b1, 1'b0, 44, 0);
        run_op("edge_neg", -32'sd2147483,   10'sd1,    -32'sd2147483000, 1'b0, 1'b0, 44, 0);
        run_op("nn_ovf",   -32'sd2147484,   -10'sd1,   32'h7FFF_FFFF,   1'b1, 1'b0, 44, 0);
        run_op("wmax",     32'sd1000000,    10'sd511,  32'd1956947,     1'b0, 1'b0, 44, 0);
        run_op("zero_num", 32'sd0,          -10'sd5,   32'd0,           1'b0, 1'b0, 44, 0);
        run_op("ign_start", 32'sd500,       10'sd250,  32'd2000,        1'b0, 1'b0, 44, 10);
        run_reset_mid();
        run_op("after_rst", -32'sd7,        10'sd3,    -32'sd2333,      1'b0, 1'b0, 44, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
